// File: rtl/vme_cmd_sequencer.sv
// rtl/vme_cmd_sequencer.sv - VME command program player with timeout detection and result FIFO
module vme_cmd_sequencer #(
  parameter int          DATA_W    = 16,
  parameter int          CMD_W     = 16,
  parameter int          DEPTH     = 64,
  parameter int          RES_DEPTH = 16,
  parameter logic [31:0] MASK      = 32'h00a80000,
  parameter int          TIMEOUT   = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [1:0]                 load_op,
  input  logic [CMD_W-1:0]           load_cmd,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       go,
  input  logic [$clog2(DEPTH):0]     num_cmds,
  input  logic                       vme_cmd_rd,
  input  logic                       vme_dat_wr,
  input  logic [31:0]                vme_dat_reg_out,
  output logic                       start,
  output logic [31:0]                vme_cmd_reg,
  output logic [31:0]                vme_dat_reg_in,
  input  logic                       res_rd,
  output logic                       res_valid,
  output logic [1:0]                 res_op,
  output logic [CMD_W-1:0]           res_cmd,
  output logic [DATA_W-1:0]          res_data,
  output logic                       res_err,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RES_DEPTH);
  localparam int EW = 2 + CMD_W + DATA_W + 1;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WAIT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_RESP, S_WAIT_CNT, S_NEXT, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [1:0]        r_mem_op   [DEPTH];
  logic [CMD_W-1:0]  r_mem_cmd  [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];

  logic [1:0]        r_op;
  logic [CMD_W-1:0]  r_cmd;
  logic [DATA_W-1:0] r_data;
  logic [AW:0]       r_pc, r_num;
  logic [31:0]       r_cnt;
  logic              r_timeout_err;

  logic [EW-1:0]     r_fifo [RES_DEPTH];
  logic [RW:0]       r_wr_ptr, r_rd_ptr;

  logic              w_busy, w_full, w_empty, w_pop;
  logic              w_resp, w_tmo, w_push, w_issue, w_cnt_done;
  logic [AW:0]       w_pc_inc;
  logic [RW:0]       w_count;
  logic [DATA_W-1:0] w_push_data;
  logic [EW-1:0]     w_entry, w_head;
  logic              w_unused;

  assign w_busy     = (r_state != S_IDLE);
  assign w_pc_inc   = r_pc + 1'b1;
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_count == (RW+1)'(RES_DEPTH));
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_pop      = res_rd && !w_empty;
  // A response arriving on the final timeout cycle wins over the timeout.
  assign w_resp     = (r_state == S_WAIT_RESP) && vme_dat_wr;
  assign w_tmo      = (r_state == S_WAIT_RESP) && !vme_dat_wr && (r_cnt == 32'(TIMEOUT - 1));
  assign w_push     = w_resp || w_tmo;
  assign w_issue    = (r_state == S_ISSUE) && vme_cmd_rd && !w_full;
  assign w_cnt_done = (r_cnt == 32'(r_data));
  assign w_unused   = ^vme_dat_reg_out;

  always_ff @(posedge clk) begin
    if (load_en && !w_busy) begin
      r_mem_op[load_addr]   <= load_op;
      r_mem_cmd[load_addr]  <= load_cmd;
      r_mem_data[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (go) w_next = (num_cmds == '0) ? S_DONE : S_FETCH;
      S_FETCH:     w_next = S_DECODE;
      S_DECODE: begin
        if (r_op == OP_NOP)       w_next = S_NEXT;
        else if (r_op == OP_WAIT) w_next = S_WAIT_CNT;
        else                      w_next = S_ISSUE;
      end
      S_ISSUE:     if (w_issue) w_next = S_WAIT_RESP;
      S_WAIT_RESP: if (w_push) w_next = S_NEXT;
      S_WAIT_CNT:  if (w_cnt_done) w_next = S_NEXT;
      S_NEXT:      w_next = (w_pc_inc == r_num) ? S_DONE : S_FETCH;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    start          = w_issue;
    vme_cmd_reg    = MASK;
    vme_dat_reg_in = '0;
    if (w_issue) begin
      vme_cmd_reg    = MASK | 32'(r_cmd) | ((r_op == OP_READ) ? 32'h0200_0000 : 32'h0100_0000);
      vme_dat_reg_in = 32'(r_data);
    end
    busy = w_busy;
    done = (r_state == S_DONE);
  end

  // r_cnt restarts on every state change, so it counts cycles spent in the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_num         <= '0;
      r_cnt         <= '0;
      r_op          <= '0;
      r_cmd         <= '0;
      r_data        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != w_next) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
      if (r_state == S_IDLE && go) begin
        r_num         <= num_cmds;
        r_pc          <= '0;
        r_timeout_err <= 1'b0;
      end
      if (r_state == S_FETCH) begin
        r_op   <= r_mem_op[r_pc[AW-1:0]];
        r_cmd  <= r_mem_cmd[r_pc[AW-1:0]];
        r_data <= r_mem_data[r_pc[AW-1:0]];
      end
      if (r_state == S_NEXT) r_pc <= w_pc_inc;
      if (w_tmo) r_timeout_err <= 1'b1;
    end
  end

  assign w_push_data = !w_resp ? '0 : (r_op == OP_READ) ? vme_dat_reg_out[DATA_W-1:0] : r_data;
  assign w_entry     = {r_op, r_cmd, w_push_data, !w_resp};

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr[RW-1:0]] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign w_head      = r_fifo[r_rd_ptr[RW-1:0]];
  assign res_valid   = !w_empty;
  assign res_op      = w_head[EW-1 -: 2];
  assign res_cmd     = w_head[EW-3 -: CMD_W];
  assign res_data    = w_head[DATA_W:1];
  assign res_err     = w_head[0];
  assign timeout_err = r_timeout_err;

endmodule
